// File: rtl/delay_timer_arbiter.sv
// delay_timer_arbiter: one prescaled countdown timer shared round-robin among
// N_REQ requesters. Each winner gets its requested tick delay counted and a
// one-cycle done pulse when it expires.
module delay_timer_arbiter #(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned TICK_W   = 16,
   parameter int unsigned PRESCALE = 50000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*TICK_W-1:0]   req_ticks,
   output logic [N_REQ-1:0]          grant,
   output logic [N_REQ-1:0]          done,
   output logic                      busy,
   output logic                      tick,
   output logic [TICK_W-1:0]         remaining
);

   localparam int unsigned PTR_W = $clog2(N_REQ);
   localparam int unsigned PS_W  = $clog2(PRESCALE);
   localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(PRESCALE - 1);
   localparam logic [PS_W-1:0]  PS_PRE    = PS_W'(PRESCALE - 2);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_REQ - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state;
   logic [PTR_W-1:0]    ptr;
   logic [PTR_W-1:0]    win;
   logic [PS_W-1:0]     presc;

   logic                found;
   logic [PTR_W-1:0]    pick;
   logic [N_REQ-1:0]    pick_oh;
   logic [TICK_W-1:0]   pick_ticks;
   logic [PTR_W-1:0]    ptr_next;
   logic [TICK_W-1:0]   ticks_arr [N_REQ];

   // Unflatten the per-requester delay bus.
   for (genvar i = 0; i < N_REQ; i++) begin : g_slice
      assign ticks_arr[i] = req_ticks[i*TICK_W +: TICK_W];
   end

   // Round-robin search: first set req bit starting at ptr, wrapping.
   always_comb begin
      int unsigned s;
      s     = 0;
      found = 1'b0;
      pick  = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         s = 32'(ptr) + k;
         if (s >= N_REQ) s = s - N_REQ;
         if (!found && req[PTR_W'(s)]) begin
            found = 1'b1;
            pick  = PTR_W'(s);
         end
      end
      pick_oh    = N_REQ'(1) << pick;
      pick_ticks = ticks_arr[pick];
      ptr_next   = (win == PTR_LAST) ? '0 : win + PTR_W'(1);
   end

   // Arbiter / timer FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         win       <= '0;
         presc     <= '0;
         grant     <= '0;
         done      <= '0;
         busy      <= 1'b0;
         tick      <= 1'b0;
         remaining <= '0;
      end else begin
         done <= '0;
         tick <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  win       <= pick;
                  remaining <= pick_ticks;
                  presc     <= '0;
                  grant     <= pick_oh;
                  busy      <= 1'b1;
                  if (pick_ticks == '0) begin
                     state <= DONE;
                     done  <= pick_oh;
                  end else begin
                     state <= RUN;
                  end
               end else begin
                  grant     <= '0;
                  busy      <= 1'b0;
                  remaining <= '0;
               end
            end
            RUN: begin
               if (!req[win]) begin
                  // Abandon takes priority over a coincident wrap.
                  state     <= IDLE;
                  grant     <= '0;
                  busy      <= 1'b0;
                  remaining <= '0;
                  ptr       <= ptr_next;
               end else if (presc == PS_LAST) begin
                  presc     <= '0;
                  remaining <= remaining - TICK_W'(1);
                  if (remaining == TICK_W'(1)) begin
                     state <= DONE;
                     done  <= grant;
                  end
               end else begin
                  presc <= presc + PS_W'(1);
                  // tick is registered, so raise it one cycle ahead of the wrap.
                  if (presc == PS_PRE) tick <= 1'b1;
               end
            end
            DONE: begin
               state     <= IDLE;
               grant     <= '0;
               busy      <= 1'b0;
               remaining <= '0;
               ptr       <= ptr_next;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Directed bench for delay_timer_arbiter with PRESCALE=4, N_REQ=4, TICK_W=16.
module tb_delay_timer_arbiter;

   localparam int PS = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [63:0] req_ticks = '0;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        busy;
   logic        tick;
   logic [15:0] remaining;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   delay_timer_arbiter #(.N_REQ(4), .TICK_W(16), .PRESCALE(PS)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_ticks (req_ticks),
      .grant     (grant),
      .done      (done),
      .busy      (busy),
      .tick      (tick),
      .remaining (remaining)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ticks(input int i, input logic [15:0] v);
      req_ticks[i*16 +: 16] = v;
   endtask

   task automatic chk(input string tag, input logic [3:0] g, input logic [3:0] d,
                      input logic b, input logic t, input logic [15:0] r);
      logic [25:0] obs;
      logic [25:0] exp;
      obs = {grant, done, busy, tick, remaining};
      exp = {g, d, b, t, r};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs: grant=%b done=%b busy=%b tick=%b rem=%0d exp: grant=%b done=%b busy=%b tick=%b rem=%0d",
                tag, grant, done, busy, tick, remaining, g, d, b, t, r);
      end
   endtask

   // Follows one grant of d ticks from the cycle after selection through the
   // done cycle and the following idle gap; rel drops all requests at done.
   task automatic serve(input string tag, input logic [3:0] oh, input int d, input bit rel);
      int last;
      last = PS*d + 1;
      for (int k = 1; k <= last; k++) begin
         cyc();
         chk($sformatf("%s_k%0d", tag, k), oh, (k == last) ? oh : 4'b0000, 1'b1,
             (k < last) && (k % PS == 0),
             (k < last) ? 16'(d - (k-1)/PS) : 16'd0);
         if (k == last && rel) req = '0;
      end
      cyc();
      chk($sformatf("%s_gap", tag), '0, '0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      // Reset state
      cyc(); cyc();
      chk("reset", '0, '0, 1'b0, 1'b0, '0);
      rst = 1'b0;
      cyc();
      chk("idle_noreq", '0, '0, 1'b0, 1'b0, '0);

      // Single request, 3 ticks: done 13 cycles after sampling
      set_ticks(0, 16'd3);
      req = 4'b0001;
      serve("single", 4'b0001, 3, 1'b1);

      // Zero delay on requester 2 (pointer now 1)
      set_ticks(2, 16'd0);
      req = 4'b0100;
      serve("zero", 4'b0100, 0, 1'b1);

      // Round-robin from reset with all requests held, 1 tick each
      rst = 1'b1;
      cyc();
      chk("reset2", '0, '0, 1'b0, 1'b0, '0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) set_ticks(i, 16'd1);
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         logic [3:0] oh;
         oh = 4'b0001 << (g % 4);
         serve($sformatf("rr%0d", g), oh, 1, g == 4);
      end

      // Abandon: requester 1 drops after two ticks, pending 3 served next
      set_ticks(1, 16'd10);
      set_ticks(3, 16'd1);
      req = 4'b1010;
      for (int k = 1; k <= 9; k++) begin
         cyc();
         chk($sformatf("abn_k%0d", k), 4'b0010, '0, 1'b1, (k == 4) || (k == 8),
             (k <= 4) ? 16'd10 : (k <= 8) ? 16'd9 : 16'd8);
      end
      req = 4'b1000;
      cyc();
      chk("abn_idle", '0, '0, 1'b0, 1'b0, '0);
      serve("abn_r3", 4'b1000, 1, 1'b1);

      // Zero delay on requester 1 to move the pointer to 2
      set_ticks(1, 16'd0);
      req = 4'b0010;
      serve("ptr2", 4'b0010, 0, 1'b1);

      // Reset mid-run during the 3rd tick of a 5-tick delay
      set_ticks(0, 16'd5);
      set_ticks(2, 16'd7);
      req = 4'b0001;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         chk($sformatf("rstrun_k%0d", k), 4'b0001, '0, 1'b1, (k % PS == 0),
             (k <= 4) ? 16'd5 : (k <= 8) ? 16'd4 : 16'd3);
      end
      rst = 1'b1;
      req = 4'b0101;
      cyc();
      chk("rst_mid", '0, '0, 1'b0, 1'b0, '0);
      rst = 1'b0;
      // Pointer back at 0: requester 0 wins over 2 with a full 5-tick delay
      serve("rerun", 4'b0001, 5, 1'b1);

      // Ticks changed after selection are ignored (pointer now 1)
      set_ticks(0, 16'd2);
      req = 4'b0001;
      for (int k = 1; k <= 10; k++) begin
         cyc();
         if (k <= 9)
            chk($sformatf("tchg_k%0d", k), 4'b0001, (k == 9) ? 4'b0001 : 4'b0000, 1'b1,
                (k == 4) || (k == 8), (k <= 4) ? 16'd2 : (k <= 8) ? 16'd1 : 16'd0);
         else
            chk("tchg_gap", '0, '0, 1'b0, 1'b0, '0);
         if (k == 1) set_ticks(0, 16'd9);
         if (k == 9) req = '0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
